// File: rtl/axi4l_pkg.sv
// Shared types for the AXI4-Lite two-master arbiter: response codes and the
// write/read path state encodings.
package axi4l_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle. The master modport drives requests; the slave modport drives
// readies and responses.
interface axi4l_if import axi4l_pkg::*; #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   axi_resp_t               bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   axi_resp_t               rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi4l_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to ptr.
module axi4l_rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       gnt,
   output logic       gnt_valid
);

   assign gnt_valid = |req;
   assign gnt       = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/axi4l_arb2.sv
// Two-master to one-slave AXI4-Lite arbiter. Write and read paths are arbitrated
// independently with a registered round-robin grant and combinational forwarding.
module axi4l_arb2 import axi4l_pkg::*; #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic      aclk,
   input logic      aresetn,
   axi4l_if.slave   s0,
   axi4l_if.slave   s1,
   axi4l_if.master  m
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   // ---------------- write path ----------------
   wr_state_t wr_state_q;
   logic      wr_sel_q, wr_ptr_q, aw_done_q, w_done_q;
   logic      wr_gnt, wr_gnt_valid, wr_fwd, wr_resp;
   logic      aw_fire, w_fire, b_fire, aw_hs, w_hs, b_hs;

   logic [ADDR_WIDTH-1:0] g_awaddr;
   logic [2:0]            g_awprot;
   logic [DATA_WIDTH-1:0] g_wdata;
   logic [STRB_WIDTH-1:0] g_wstrb;
   logic                  g_awvalid, g_wvalid, g_bready;

   axi4l_rr_pick2 u_wr_pick (
      .req       ({s1.awvalid, s0.awvalid}),
      .ptr       (wr_ptr_q),
      .gnt       (wr_gnt),
      .gnt_valid (wr_gnt_valid)
   );

   assign g_awaddr  = wr_sel_q ? s1.awaddr  : s0.awaddr;
   assign g_awprot  = wr_sel_q ? s1.awprot  : s0.awprot;
   assign g_awvalid = wr_sel_q ? s1.awvalid : s0.awvalid;
   assign g_wdata   = wr_sel_q ? s1.wdata   : s0.wdata;
   assign g_wstrb   = wr_sel_q ? s1.wstrb   : s0.wstrb;
   assign g_wvalid  = wr_sel_q ? s1.wvalid  : s0.wvalid;
   assign g_bready  = wr_sel_q ? s1.bready  : s0.bready;

   assign wr_fwd  = (wr_state_q == W_FWD);
   assign wr_resp = (wr_state_q == W_RESP);
   assign aw_fire = wr_fwd & g_awvalid & ~aw_done_q;
   assign w_fire  = wr_fwd & g_wvalid & ~w_done_q;
   assign b_fire  = wr_resp & g_bready;
   assign aw_hs   = aw_fire & m.awready;
   assign w_hs    = w_fire & m.wready;
   assign b_hs    = b_fire & m.bvalid;

   always_comb begin
      m.awaddr  = wr_fwd ? g_awaddr : '0;
      m.awprot  = wr_fwd ? g_awprot : '0;
      m.awvalid = aw_fire;
      m.wdata   = wr_fwd ? g_wdata : '0;
      m.wstrb   = wr_fwd ? g_wstrb : '0;
      m.wvalid  = w_fire;
      m.bready  = b_fire;
      s0.awready = 1'b0;
      s0.wready  = 1'b0;
      s0.bvalid  = 1'b0;
      s0.bresp   = OKAY;
      s1.awready = 1'b0;
      s1.wready  = 1'b0;
      s1.bvalid  = 1'b0;
      s1.bresp   = OKAY;
      // Done flags stop a second handshake on a channel that already completed.
      if (wr_fwd && !wr_sel_q) begin
         s0.awready = m.awready & ~aw_done_q;
         s0.wready  = m.wready & ~w_done_q;
      end
      if (wr_fwd && wr_sel_q) begin
         s1.awready = m.awready & ~aw_done_q;
         s1.wready  = m.wready & ~w_done_q;
      end
      if (wr_resp && !wr_sel_q) begin
         s0.bvalid = m.bvalid;
         s0.bresp  = m.bresp;
      end
      if (wr_resp && wr_sel_q) begin
         s1.bvalid = m.bvalid;
         s1.bresp  = m.bresp;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_state_q <= W_IDLE;
         wr_sel_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         case (wr_state_q)
            W_IDLE: if (wr_gnt_valid) begin
               wr_sel_q   <= wr_gnt;
               wr_state_q <= W_FWD;
            end
            W_FWD: begin
               aw_done_q <= aw_done_q | aw_hs;
               w_done_q  <= w_done_q | w_hs;
               if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) wr_state_q <= W_RESP;
            end
            W_RESP: if (b_hs) begin
               wr_state_q <= W_IDLE;
               aw_done_q  <= 1'b0;
               w_done_q   <= 1'b0;
               wr_ptr_q   <= ~wr_sel_q;
            end
            default: wr_state_q <= W_IDLE;
         endcase
      end
   end

   // ---------------- read path ----------------
   rd_state_t rd_state_q;
   logic      rd_sel_q, rd_ptr_q;
   logic      rd_gnt, rd_gnt_valid, rd_addr, rd_data, ar_fire, r_fire, ar_hs, r_hs;

   logic [ADDR_WIDTH-1:0] g_araddr;
   logic [2:0]            g_arprot;
   logic                  g_arvalid, g_rready;

   axi4l_rr_pick2 u_rd_pick (
      .req       ({s1.arvalid, s0.arvalid}),
      .ptr       (rd_ptr_q),
      .gnt       (rd_gnt),
      .gnt_valid (rd_gnt_valid)
   );

   assign g_araddr  = rd_sel_q ? s1.araddr  : s0.araddr;
   assign g_arprot  = rd_sel_q ? s1.arprot  : s0.arprot;
   assign g_arvalid = rd_sel_q ? s1.arvalid : s0.arvalid;
   assign g_rready  = rd_sel_q ? s1.rready  : s0.rready;

   assign rd_addr = (rd_state_q == R_ADDR);
   assign rd_data = (rd_state_q == R_DATA);
   assign ar_fire = rd_addr & g_arvalid;
   assign r_fire  = rd_data & g_rready;
   assign ar_hs   = ar_fire & m.arready;
   assign r_hs    = r_fire & m.rvalid;

   always_comb begin
      m.araddr   = rd_addr ? g_araddr : '0;
      m.arprot   = rd_addr ? g_arprot : '0;
      m.arvalid  = ar_fire;
      m.rready   = r_fire;
      s0.arready = rd_addr & ~rd_sel_q & m.arready;
      s1.arready = rd_addr & rd_sel_q & m.arready;
      s0.rvalid  = rd_data & ~rd_sel_q & m.rvalid;
      s1.rvalid  = rd_data & rd_sel_q & m.rvalid;
      s0.rdata   = (rd_data && !rd_sel_q) ? m.rdata : '0;
      s1.rdata   = (rd_data && rd_sel_q) ? m.rdata : '0;
      s0.rresp   = (rd_data && !rd_sel_q) ? m.rresp : OKAY;
      s1.rresp   = (rd_data && rd_sel_q) ? m.rresp : OKAY;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_state_q <= R_IDLE;
         rd_sel_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else begin
         case (rd_state_q)
            R_IDLE: if (rd_gnt_valid) begin
               rd_sel_q   <= rd_gnt;
               rd_state_q <= R_ADDR;
            end
            R_ADDR: if (ar_hs) rd_state_q <= R_DATA;
            R_DATA: if (r_hs) begin
               rd_state_q <= R_IDLE;
               rd_ptr_q   <= ~rd_sel_q;
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   // ---------------- protocol checks ----------------
   logic [1:0] wr_gnt_vec, rd_gnt_vec;
   assign wr_gnt_vec = (wr_state_q == W_IDLE) ? 2'b00 : (wr_sel_q ? 2'b10 : 2'b01);
   assign rd_gnt_vec = (rd_state_q == R_IDLE) ? 2'b00 : (rd_sel_q ? 2'b10 : 2'b01);

   a_wr_onehot: assert property (@(posedge aclk) $onehot0(wr_gnt_vec));
   a_rd_onehot: assert property (@(posedge aclk) $onehot0(rd_gnt_vec));
   a_s0_quiet: assert property (@(posedge aclk) disable iff (!aresetn)
      !(!wr_gnt_vec[0] && (s0.awready || s0.wready || s0.bvalid)) &&
      !(!rd_gnt_vec[0] && (s0.arready || s0.rvalid)));
   a_s1_quiet: assert property (@(posedge aclk) disable iff (!aresetn)
      !(!wr_gnt_vec[1] && (s1.awready || s1.wready || s1.bvalid)) &&
      !(!rd_gnt_vec[1] && (s1.arready || s1.rvalid)));
   a_m_aw_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      m.awvalid && !m.awready |=> m.awvalid);
   a_m_w_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      m.wvalid && !m.wready |=> m.wvalid);
   a_m_ar_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      m.arvalid && !m.arready |=> m.arvalid);
   a_up_aw_hold: assert property (@(posedge aclk) disable iff (!aresetn)
      wr_fwd && !aw_done_q && !aw_hs |=> g_awvalid);
   a_up_w_hold: assert property (@(posedge aclk) disable iff (!aresetn)
      wr_fwd && !w_done_q && !w_hs |=> g_wvalid);
   a_up_ar_hold: assert property (@(posedge aclk) disable iff (!aresetn)
      rd_addr && !ar_hs |=> g_arvalid);

endmodule
